add_accumulate: RTL and testbench
=================================

# add_accumulate

Accumulates the registered per-cycle sums produced by the adder-tree stage (`Add_base`) over a group of `NUM_ACC` consecutive beats and emits one saturated result per group. It sits directly downstream of the adder tree and turns per-tap partial sums into a final per-output-channel value. It adds a valid/ready handshake with a one-entry output register so the next stage can stall it.

## Interface
- `BIT_IN`, 28, width of the incoming adder-tree sum (unsigned).
- `BIT_ACC`, 32, internal accumulator width.
- `BIT_OUT`, 24, output width; must satisfy `BIT_OUT <= BIT_ACC`.
- `NUM_ACC`, 9, beats per group; must be ≥ 1.
- `clk`, input, 1, clock; all logic is on the rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `in_valid`, input, 1, `in` carries a beat.
- `in_ready`, output, 1, block accepts a beat this cycle.
- `in`, input, `BIT_IN`, unsigned partial sum.
- `in_last`, input, 1, force this beat to close the group early.
- `out_valid`, output, 1, `out` holds a group result.
- `out_ready`, input, 1, downstream consumes `out`.
- `out`, output, `BIT_OUT`, saturated group sum.
- `out_sat`, output, 1, a saturation occurred somewhere in this group.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = `!out_valid || out_ready`. This is combinational from the output register state and `out_ready`.
- Beat counter `cnt`: range 0..`NUM_ACC-1`, reset value 0.
- Accumulator `acc`: width `BIT_ACC`, reset value 0. Sticky flag `sat_acc`, reset value 0.
- For each accepted beat, compute `sum = acc + zero-extended in` at `BIT_ACC+1` bits.
  - If bit `BIT_ACC` of `sum` is set, clamp to all-ones and set the sticky saturation flag.
- Final beat: an accepted beat with `cnt == NUM_ACC-1` or `in_last == 1`.
  - Load `out` with the clamped sum, further clamped to `BIT_OUT`: if any bit above `BIT_OUT-1` is set, `out` = all-ones and saturation is flagged.
  - Load `out_sat` with the sticky flag OR'd with this beat's saturation.
  - Set `out_valid` = 1.
  - Clear `acc`, `cnt` and the sticky flag.
- Non-final beat: `acc` ← clamped sum, `cnt` ← `cnt+1`, sticky flag updated.
- Output handshake: when `out_valid && out_ready` and no final beat is accepted in the same cycle, clear `out_valid`. `out` and `out_sat` hold their values.
  - If a final beat is accepted in that same cycle, the output register is reloaded and `out_valid` stays 1. This gives back-to-back results with no bubble.
- While `out_valid && !out_ready`, all input is stalled. `acc` and `cnt` hold; no partial accumulation continues.
- Reset: `out` = 0, `out_sat` = 0, `out_valid` = 0, `acc` = 0, `cnt` = 0. Reset mid-group discards the partial sum; the first beat after reset starts a new group at `cnt` = 0.
- `NUM_ACC` = 1: every accepted beat is a final beat.

## Timing
- Latency: `out_valid` rises on the edge that accepts the final beat, so it is visible in the cycle after that beat is presented.
- Throughput: one beat per cycle whenever `out_ready` stays high; one result every `NUM_ACC` cycles.
- `in_valid` low cycles (bubbles) inside a group are allowed; state holds through them.
- `in_last` is ignored when `in_valid` is low.
- No combinational path from `in` or `in_valid` to any output. The only combinational output path is `out_ready` → `in_ready`.

## Structure
- Shared package `add_pkg`: default widths (`BIT_IN`, `BIT_ACC`, `BIT_OUT`, `NUM_ACC`) and a function `sat_clip(value, width)` that returns the clamped value plus an overflow bit. Both clamps in this block use it.
- One sub-module: `add_acc_outreg`, the one-entry output register with the valid/ready logic. The counter and accumulator stay in the top module.

## Test plan
- Defaults, `in` = 10 for 9 consecutive beats, `out_ready` = 1 → one result `out` = 90, `out_sat` = 0, with `out_valid` high for exactly 1 cycle, the cycle after beat 9.
- Beats 5, 7, 3 with `in_last` on the third beat → `out` = 15; the next group restarts at `cnt` = 0.
- 9 beats of `in` = 2^27−1 → `out` = 2^24−1, `out_sat` = 1. The next group of zeros gives `out` = 0, `out_sat` = 0.
- `out_ready` held low for 5 cycles after a result → `in_ready` = 0, `out` stable, `acc` and `cnt` frozen. On release, the result is consumed and accumulation resumes without loss.
- Continuous input with `out_ready` = 1, `NUM_ACC` = 1, `in` = 1, 2, 3 → `out` = 1, 2, 3 on consecutive cycles with `out_valid` high throughout.
- Assert `rst` after 4 beats of 10 → all outputs 0. Then 9 beats of 1 give `out` = 9, with no residue from the discarded partial sum.

Source files
------------

// File: rtl/add_pkg.sv
// Shared widths and saturation helper for the adder-tree accumulation stage.
package add_pkg;

   localparam int unsigned DEF_BIT_IN  = 28;
   localparam int unsigned DEF_BIT_ACC = 32;
   localparam int unsigned DEF_BIT_OUT = 24;
   localparam int unsigned DEF_NUM_ACC = 9;

   // Working width of sat_clip; every clamp in this block is narrower.
   localparam int unsigned SAT_W = 64;

   typedef struct packed {
      logic             ovf;
      logic [SAT_W-1:0] val;
   } sat_t;

   // Clamp value to an unsigned field of the given width, reporting overflow.
   function automatic sat_t sat_clip(input logic [SAT_W-1:0] value, input int unsigned width);
      logic [SAT_W-1:0] mask;
      sat_t             r;
      mask  = (SAT_W'(1) << width) - SAT_W'(1);
      r.ovf = |(value & ~mask);
      r.val = r.ovf ? mask : value;
      return r;
   endfunction

endpackage

// File: rtl/add_acc_outreg.sv
// One-entry output register with valid/ready; reloads in place so results can
// leave back-to-back without a bubble.
module add_acc_outreg #(
   parameter int unsigned BIT_OUT = add_pkg::DEF_BIT_OUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [BIT_OUT-1:0] load_data,
   input  logic               load_sat,
   input  logic               out_ready,
   output logic               in_ready,
   output logic               out_valid,
   output logic [BIT_OUT-1:0] out,
   output logic               out_sat
);

   logic               valid_q;
   logic [BIT_OUT-1:0] data_q;
   logic               sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sat_q   <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
         sat_q   <= load_sat;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out       = data_q;
   assign out_sat   = sat_q;

endmodule

// File: rtl/add_accumulate.sv
// Accumulates NUM_ACC adder-tree sums (or fewer, closed by in_last) into one
// saturated result per group behind a one-entry output register.
module add_accumulate
   import add_pkg::*;
#(
   parameter int unsigned BIT_IN  = DEF_BIT_IN,
   parameter int unsigned BIT_ACC = DEF_BIT_ACC,
   parameter int unsigned BIT_OUT = DEF_BIT_OUT,
   parameter int unsigned NUM_ACC = DEF_NUM_ACC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BIT_IN-1:0]  in,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BIT_OUT-1:0] out,
   output logic               out_sat
);

   localparam int unsigned CNT_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_ACC-1:0] acc_q, acc_d;
   logic               sat_q, sat_d;

   logic               accept;
   logic               final_beat;
   logic [BIT_ACC:0]   sum;
   logic [SAT_W-1:0]   sum_ext;
   logic [SAT_W-1:0]   acc_ext;
   sat_t               acc_clip;
   sat_t               out_clip;
   logic [BIT_ACC-1:0] acc_sum;
   logic [BIT_OUT-1:0] load_data;
   logic               load_sat;

   assign accept = in_valid && in_ready;

   always_comb begin
      sum       = {1'b0, acc_q} + (BIT_ACC + 1)'(in);
      sum_ext   = SAT_W'(sum);
      acc_clip  = sat_clip(sum_ext, BIT_ACC);
      acc_sum   = acc_clip.val[BIT_ACC-1:0];
      acc_ext   = SAT_W'(acc_sum);
      out_clip  = sat_clip(acc_ext, BIT_OUT);
      load_data = out_clip.val[BIT_OUT-1:0];
      load_sat  = sat_q | acc_clip.ovf | out_clip.ovf;

      final_beat = accept && ((cnt_q == CNT_W'(NUM_ACC - 1)) || in_last);

      cnt_d = cnt_q;
      acc_d = acc_q;
      sat_d = sat_q;
      if (final_beat) begin
         cnt_d = '0;
         acc_d = '0;
         sat_d = 1'b0;
      end else if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
         acc_d = acc_sum;
         sat_d = sat_q | acc_clip.ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   // Bits above the clamp width are zero by construction.
   logic unused_clip_bits;
   assign unused_clip_bits = ^{acc_clip.val[SAT_W-1:BIT_ACC], out_clip.val[SAT_W-1:BIT_OUT]};

   add_acc_outreg #(
      .BIT_OUT (BIT_OUT)
   ) u_outreg (
      .clk       (clk),
      .rst       (rst),
      .load      (final_beat),
      .load_data (load_data),
      .load_sat  (load_sat),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out       (out),
      .out_sat   (out_sat)
   );

endmodule

// File: tb/tb_add_accumulate.sv
// Directed bench: default-parameter instance plus a NUM_ACC=1 instance.
module tb_add_accumulate;

   logic clk;
   logic rst;

   logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_sat;
   logic [27:0] a_in;
   logic [23:0] a_out;

   logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat;
   logic [27:0] b_in;
   logic [23:0] b_out;

   int n_cmp;
   int n_fail;

   add_accumulate u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in        (a_in),
      .in_last   (a_in_last),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out       (a_out),
      .out_sat   (a_out_sat)
   );

   add_accumulate #(
      .NUM_ACC (1)
   ) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in        (b_in),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out       (b_out),
      .out_sat   (b_out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [27:0] v, input logic last);
      a_in_valid = 1'b1;
      a_in       = v;
      a_in_last  = last;
      step();
   endtask

   task automatic idle_a();
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 1'b0; a_in = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
      step();
      step();
      n_cmp++;
      if (a_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
      end
      n_cmp++;
      if (a_out !== 24'd0) begin
         n_fail++; $display("FAIL reset_out: got %0d want 0", a_out);
      end
      n_cmp++;
      if (a_out_sat !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_sat: got %b want 0", a_out_sat);
      end
      n_cmp++;
      if (a_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int early;
      early = 0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_a(28'd10, 1'b0);
         if (i < 8 && a_out_valid === 1'b1) early++;
      end
      n_cmp++;
      if (early !== 0) begin
         n_fail++; $display("FAIL basic_early_valid: got %0d cycles want 0", early);
      end
      n_cmp++;
      if (a_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL basic_valid: got %b want 1", a_out_valid);
      end
      n_cmp++;
      if (a_out !== 24'd90) begin
         n_fail++; $display("FAIL basic_out: got %0d want 90", a_out);
      end
      n_cmp++;
      if (a_out_sat !== 1'b0) begin
         n_fail++; $display("FAIL basic_sat: got %b want 0", a_out_sat);
      end
      idle_a();
      n_cmp++;
      if (a_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_valid_drop: got %b want 0", a_out_valid);
      end
   endtask

   task automatic test_last();
      int early;
      early = 0;
      a_out_ready = 1'b1;
      drive_a(28'd5, 1'b0);
      drive_a(28'd7, 1'b0);
      drive_a(28'd3, 1'b1);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out !== 24'd15) begin
         n_fail++; $display("FAIL last_out: got valid %b out %0d want valid 1 out 15",
                            a_out_valid, a_out);
      end
      // Following group must need a full nine beats.
      for (int i = 0; i < 9; i++) begin
         drive_a(28'd1, 1'b0);
         if (i < 8 && a_out_valid === 1'b1) early++;
      end
      n_cmp++;
      if (early !== 0) begin
         n_fail++; $display("FAIL last_restart_early: got %0d cycles want 0", early);
      end
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out !== 24'd9) begin
         n_fail++; $display("FAIL last_restart_out: got valid %b out %0d want valid 1 out 9",
                            a_out_valid, a_out);
      end
      idle_a();
   endtask

   task automatic test_saturate();
      a_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) drive_a(28'h7FF_FFFF, 1'b0);
      n_cmp++;
      if (a_out !== 24'hFF_FFFF) begin
         n_fail++; $display("FAIL sat_out: got %0h want ffffff", a_out);
      end
      n_cmp++;
      if (a_out_sat !== 1'b1) begin
         n_fail++; $display("FAIL sat_flag: got %b want 1", a_out_sat);
      end
      for (int i = 0; i < 9; i++) drive_a(28'd0, 1'b0);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out !== 24'd0) begin
         n_fail++; $display("FAIL sat_zero_out: got valid %b out %0d want valid 1 out 0",
                            a_out_valid, a_out);
      end
      n_cmp++;
      if (a_out_sat !== 1'b0) begin
         n_fail++; $display("FAIL sat_zero_flag: got %b want 0", a_out_sat);
      end
      idle_a();
   endtask

   task automatic test_stall();
      int early;
      early = 0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) drive_a(28'd20, 1'b0);
      a_out_ready = 1'b0;
      drive_a(28'd20, 1'b0);
      // Offer beats that must not be taken while the result is held.
      a_in_valid = 1'b1;
      a_in       = 28'd100;
      a_in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, a_in_ready);
         end
         step();
         n_cmp++;
         if (a_out_valid !== 1'b1 || a_out !== 24'd180) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got valid %b out %0d want valid 1 out 180",
                               i, a_out_valid, a_out);
         end
      end
      a_out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive_a(28'd10, 1'b0);
         if (i < 8 && a_out_valid === 1'b1) early++;
      end
      n_cmp++;
      if (early !== 0) begin
         n_fail++; $display("FAIL stall_resume_early: got %0d cycles want 0", early);
      end
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out !== 24'd90) begin
         n_fail++; $display("FAIL stall_resume_out: got valid %b out %0d want valid 1 out 90",
                            a_out_valid, a_out);
      end
      idle_a();
   endtask

   task automatic test_back_to_back();
      b_out_ready = 1'b1;
      b_in_last   = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         b_in_valid = 1'b1;
         b_in       = 28'(k);
         step();
         n_cmp++;
         if (b_out_valid !== 1'b1 || b_out !== 24'(k)) begin
            n_fail++; $display("FAIL b2b[%0d]: got valid %b out %0d want valid 1 out %0d",
                               k, b_out_valid, b_out, k);
         end
      end
      b_in_valid = 1'b0;
      step();
      n_cmp++;
      if (b_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_drop: got %b want 0", b_out_valid);
      end
   endtask

   task automatic test_reset_mid();
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) drive_a(28'd10, 1'b0);
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      rst = 1'b1;
      step();
      n_cmp++;
      if (a_out !== 24'd0 || a_out_valid !== 1'b0 || a_out_sat !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got out %0d valid %b sat %b want 0 0 0",
                            a_out, a_out_valid, a_out_sat);
      end
      rst = 1'b0;
      step();
      for (int i = 0; i < 9; i++) drive_a(28'd1, 1'b0);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out !== 24'd9) begin
         n_fail++; $display("FAIL rst_mid_after: got valid %b out %0d want valid 1 out 9",
                            a_out_valid, a_out);
      end
      idle_a();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_last();
      test_saturate();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
